// File: rtl/uart_rx_if.sv
// Consumer-side bundle of uart_rx: received word, ready/ack handshake and error flags.
// par_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int WL = 8
);
  logic          ack;
  logic [WL-1:0] data;
  logic          rdy;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          par_err;

  modport master (input ack, output data, rdy, frame_err, overrun, par_err);
  modport slave  (output ack, input data, rdy, frame_err, overrun, par_err);
`else
  modport master (input ack, output data, rdy, frame_err, overrun);
  modport slave  (output ack, input data, rdy, frame_err, overrun);
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receiver, LSB first, 1 start / WL data / 1 stop (+ even parity under UART_RX_PARITY_EN);
// rdy rises one cycle after the stop sample; an unacked word is overwritten and flagged as overrun.
module uart_rx #(
  parameter int WL       = 8,
  parameter int BAUD_DIV = 10419
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx_in,
  uart_rx_if.master  bus,
  output logic [2:0] state
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = (WL > 1) ? $clog2(WL) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
  localparam logic [IW-1:0] IDX_MAX  = IW'(WL - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_e;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_e;
`endif

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WL-1:0] shreg_q, shreg_d;
  logic [WL-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          stop_q, stop_d;
  logic          rdy_q, rdy_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          word_ok;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          par_err_q, par_err_d;
`endif

  logic fall, half_pt, bit_end;
  assign fall    = rx_prev_q & ~rx_s_q;
  assign half_pt = (cnt_q == CNT_HALF);
  assign bit_end = (cnt_q == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      stop_q      <= 1'b0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_in;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      done_q      <= done_d;
      stop_q      <= stop_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= par_bit_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (half_pt) state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_end && idx_q == IDX_MAX) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && idx_q == IDX_MAX) state_d = STOP;
`endif
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and sampling; the stop sample is staged in done_q/stop_q for the next edge.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
      end
      START: if (half_pt) cnt_d = '0;
      DATA: if (bit_end) begin
        cnt_d          = '0;
        shreg_d[idx_q] = rx_s_q;
        idx_d          = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        cnt_d     = '0;
        par_bit_d = rx_s_q;
      end
`endif
      STOP: if (bit_end) begin
        cnt_d  = '0;
        done_d = 1'b1;
        stop_d = rx_s_q;
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign word_ok = ~^{shreg_q, par_bit_q};
`else
  assign word_ok = 1'b1;
`endif

  always_comb begin
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (bus.ack && rdy_q) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (done_q) begin
      if (!stop_q) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = ~word_ok;
`endif
        if (word_ok) begin
          data_d = shreg_q;
          rdy_d  = 1'b1;
          // Ack in the same cycle consumes the old word, so no overrun.
          if (rdy_q && !bus.ack) overrun_d = 1'b1;
        end
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif
  assign state         = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at WL=8, BAUD_DIV=16; each frame bit is held 16 cycles.
// Parity scenarios are compiled in only with UART_RX_PARITY_EN.
module tb_uart_rx;
  logic       CLK;
  logic       RST_N;
  logic       rx_in;
  logic [2:0] state;
  int         checks;
  int         errors;

`ifdef UART_RX_PARITY_EN
  localparam int LAT = 172;
  logic par_flip;
`else
  localparam int LAT = 156;
`endif

  uart_rx_if #(.WL(8)) u_if ();

  uart_rx #(.WL(8), .BAUD_DIV(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .rx_in (rx_in),
    .bus   (u_if),
    .state (state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic send_frame(input logic [7:0] d, input logic stopb, input int stop_len);
    @(posedge CLK);
    #1 rx_in = 1'b0;
    repeat (16) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      #1 rx_in = d[i];
      repeat (16) @(posedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx_in = (^d) ^ par_flip;
    repeat (16) @(posedge CLK);
`endif
    #1 rx_in = stopb;
    repeat (stop_len) @(posedge CLK);
    #1 rx_in = 1'b1;
  endtask

  task automatic pulse_ack();
    @(posedge CLK);
    #1 u_if.ack = 1'b1;
    @(posedge CLK);
    #1 u_if.ack = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks += 5;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", u_if.rdy); end
    if (u_if.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", u_if.data); end
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err); end
    if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", u_if.overrun); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (5) @(posedge CLK);
  endtask

  task automatic test_good_frame();
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        @(posedge CLK);
        repeat (LAT - 1) @(posedge CLK);
        @(negedge CLK);
        checks += 2;
        if (state !== 3'd3) begin errors++; $display("FAIL lat_state_stop: got %0d want 3", state); end
        if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL lat_rdy_early: got %b want 0", u_if.rdy); end
        @(posedge CLK);
        @(negedge CLK);
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL lat_state_idle: got %0d want 0", state); end
        if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL lat_rdy_sample_edge: got %b want 0", u_if.rdy); end
        @(posedge CLK);
        @(negedge CLK);
        checks += 2;
        if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL lat_rdy_rise: got %b want 1", u_if.rdy); end
        if (u_if.data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", u_if.data); end
      end
    join
    @(negedge CLK);
    checks += 1;
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL a5_frame_err: got %b want 0", u_if.frame_err); end
    pulse_ack();
    checks += 2;
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL ack_clears_rdy: got %b want 0", u_if.rdy); end
    if (u_if.data !== 8'hA5) begin errors++; $display("FAIL ack_keeps_data: got %h want a5", u_if.data); end
  endtask

  task automatic test_glitch();
    repeat (4) @(posedge CLK);
    #1 rx_in = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    checks += 1;
    if (state !== 3'd1) begin errors++; $display("FAIL glitch_start: got %0d want 1", state); end
    @(posedge CLK);
    #1 rx_in = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    checks += 4;
    if (state !== 3'd0) begin errors++; $display("FAIL glitch_idle: got %0d want 0", state); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", u_if.rdy); end
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", u_if.frame_err); end
    if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b want 0", u_if.overrun); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 16);
    @(negedge CLK);
    checks += 3;
    if (u_if.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", u_if.frame_err); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL ferr_rdy: got %b want 0", u_if.rdy); end
    if (u_if.data !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h want a5", u_if.data); end
  endtask

  task automatic test_back_to_back();
    repeat (4) @(posedge CLK);
    send_frame(8'h11, 1'b1, 13);
    send_frame(8'h22, 1'b1, 16);
    @(negedge CLK);
    checks += 4;
    if (u_if.data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h want 22", u_if.data); end
    if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: got %b want 1", u_if.rdy); end
    if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", u_if.overrun); end
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err_clr: got %b want 0", u_if.frame_err); end
    pulse_ack();
    checks += 2;
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL ovr_ack_rdy: got %b want 0", u_if.rdy); end
    if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_overrun: got %b want 0", u_if.overrun); end
  endtask

  task automatic test_ack_collision();
    send_frame(8'h66, 1'b1, 16);
    @(negedge CLK);
    checks += 2;
    if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL col_pre_rdy: got %b want 1", u_if.rdy); end
    if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL col_pre_overrun: got %b want 0", u_if.overrun); end
    fork
      send_frame(8'h5A, 1'b1, 16);
      begin
        @(posedge CLK);
        repeat (LAT) @(posedge CLK);
        #1 u_if.ack = 1'b1;
        @(posedge CLK);
        #1 u_if.ack = 1'b0;
        @(negedge CLK);
        checks += 3;
        if (u_if.data !== 8'h5A) begin errors++; $display("FAIL col_data: got %h want 5a", u_if.data); end
        if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL col_rdy: got %b want 1", u_if.rdy); end
        if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL col_overrun: got %b want 0", u_if.overrun); end
      end
    join
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    v = 8'h99;
    repeat (4) @(posedge CLK);
    #1 rx_in = 1'b0;
    repeat (16) @(posedge CLK);
    for (int i = 0; i < 4; i++) begin
      #1 rx_in = v[i];
      repeat (16) @(posedge CLK);
    end
    #1 rx_in = v[4];
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks += 5;
    if (state !== 3'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", state); end
    if (u_if.data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", u_if.data); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL rmid_rdy: got %b want 0", u_if.rdy); end
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL rmid_frame_err: got %b want 0", u_if.frame_err); end
    if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b want 0", u_if.overrun); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (200) @(posedge CLK);
    @(negedge CLK);
    checks += 2;
    if (state !== 3'd0) begin errors++; $display("FAIL rmid_post_state: got %0d want 0", state); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL rmid_no_rdy: got %b want 0", u_if.rdy); end
    send_frame(8'h7E, 1'b1, 16);
    @(negedge CLK);
    checks += 3;
    if (u_if.data !== 8'h7E) begin errors++; $display("FAIL rmid_next_data: got %h want 7e", u_if.data); end
    if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL rmid_next_rdy: got %b want 1", u_if.rdy); end
    if (u_if.frame_err !== 1'b0) begin errors++; $display("FAIL rmid_next_ferr: got %b want 0", u_if.frame_err); end
    pulse_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    repeat (4) @(posedge CLK);
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1, 16);
    @(negedge CLK);
    checks += 3;
    if (u_if.par_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", u_if.par_err); end
    if (u_if.rdy !== 1'b0) begin errors++; $display("FAIL par_bad_rdy: got %b want 0", u_if.rdy); end
    if (u_if.data !== 8'h7E) begin errors++; $display("FAIL par_bad_data: got %h want 7e", u_if.data); end
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1, 16);
    @(negedge CLK);
    checks += 3;
    if (u_if.par_err !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", u_if.par_err); end
    if (u_if.rdy !== 1'b1) begin errors++; $display("FAIL par_good_rdy: got %b want 1", u_if.rdy); end
    if (u_if.data !== 8'h03) begin errors++; $display("FAIL par_good_data: got %h want 03", u_if.data); end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rx_in     = 1'b1;
    RST_N     = 1'b0;
    u_if.ack  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flip  = 1'b0;
`endif
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_collision();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
